// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state used by the 8E1 frame format.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_WORD_W    = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and extra-MSB pointers.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Same slot index with differing lap bits means the writer is one lap ahead.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop updates from pre-edge values.
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a valid/ready word stream
// through a small receive FIFO; bytes are zero-extended to 32 bits.
module uart_rx_axis
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   output logic [UART_WORD_W-1:0] m_axis_rdata,
   output logic                   m_axis_rvalid,
   input  logic                   m_axis_rready,
   output logic                   rx_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                   rx_parity_err,
`endif
   output logic                   rx_overflow
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_rx_state_t            r_state;
   uart_rx_state_t            w_state_next;
   logic                      r_rx_meta;
   logic                      r_rx_sync;
   logic                      r_rx_prev;
   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          w_cnt_next;
   logic [2:0]                r_bit_idx;
   logic [2:0]                w_bit_next;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic [UART_DATA_BITS-1:0] w_shift_next;
   logic                      w_cnt_zero;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_frame_err;
   logic                      w_overflow;
   logic                      r_frame_err;
   logic                      r_overflow;
   logic [UART_DATA_BITS-1:0] w_fifo_rdata;
   logic                      w_fifo_full;
   logic                      w_fifo_empty;
`ifdef UART_RX_PARITY_EN
   logic                      r_parity_bad;
   logic                      w_parity_bad_next;
   logic                      w_parity_err;
   logic                      r_parity_err;
`endif

   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_bit_next   = r_bit_idx;
      w_shift_next = r_shift;
      w_push       = 1'b0;
      w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_parity_bad_next = r_parity_bad;
      w_parity_err      = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (r_rx_prev && !r_rx_sync) begin
               w_state_next = ST_START;
               w_cnt_next   = CNT_HALF;
            end
         end
         ST_START: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - CNT_ONE;
            end else if (r_rx_sync) begin
               w_state_next = ST_IDLE;
            end else begin
               w_state_next = ST_DATA;
               w_cnt_next   = CNT_FULL;
               w_bit_next   = '0;
            end
         end
         ST_DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - CNT_ONE;
            end else begin
               w_shift_next = {r_rx_sync, r_shift[UART_DATA_BITS-1:1]};
               w_cnt_next   = CNT_FULL;
               w_bit_next   = r_bit_idx + 3'd1;
               if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  w_state_next = ST_PARITY;
`else
                  w_state_next = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - CNT_ONE;
            end else begin
               w_parity_bad_next = ^{r_shift, r_rx_sync};
               w_cnt_next        = CNT_FULL;
               w_state_next      = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - CNT_ONE;
            end else begin
               w_state_next = ST_IDLE;
               // A bad stop bit wins over a parity mismatch.
               if (!r_rx_sync) begin
                  w_frame_err = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (r_parity_bad) begin
                  w_parity_err = 1'b1;
`endif
               end else begin
                  w_push = 1'b1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   assign w_pop      = m_axis_rvalid && m_axis_rready;
   assign w_overflow = w_push && w_fifo_full && !w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta   <= 1'b1;
         r_rx_sync   <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_rx_meta   <= rx;
         r_rx_sync   <= r_rx_meta;
         r_rx_prev   <= r_rx_sync;
         r_cnt       <= w_cnt_next;
         r_bit_idx   <= w_bit_next;
         r_shift     <= w_shift_next;
         r_frame_err <= w_frame_err;
         r_overflow  <= w_overflow;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity_bad <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_parity_bad <= w_parity_bad_next;
         r_parity_err <= w_parity_err;
      end
   end

   assign rx_parity_err = r_parity_err;
`endif

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (r_shift),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Data is forced to zero while empty so the bus never shows stale storage.
   assign m_axis_rvalid = !w_fifo_empty;
   assign m_axis_rdata  = m_axis_rvalid ?
                          {{(UART_WORD_W - UART_DATA_BITS){1'b0}}, w_fifo_rdata} : '0;
   assign rx_frame_err  = r_frame_err;
   assign rx_overflow   = r_overflow;

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

Serial UART receiver that turns an asynchronous 8N1 line into 32-bit words on a valid/ready stream. It feeds the receive side of the AXI-lite-to-stream bridge (`m_axis_rdata/rvalid/rready`), which today is tied off. The block is the counterpart of the debug TX stream: the core reads received bytes through the UART slot on the AXI-lite crossbar. A small FIFO absorbs bytes while the core is busy.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per UART bit; must be at least 4.
- `FIFO_DEPTH`, 8, receive FIFO entries; must be a power of two, at least 2.
- `clk` in 1, single clock for all logic.
- `rst` in 1, reset; synchronous, active-high.
- `rx` in 1, asynchronous serial input; idles high.
- `m_axis_rdata` out 32, received byte in `{24'b0, byte}`.
- `m_axis_rvalid` out 1, FIFO not empty.
- `m_axis_rready` in 1, consumer accepts the word.
- `rx_frame_err` out 1, one-cycle pulse when a stop bit is sampled low.
- `rx_overflow` out 1, one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Input sync:** `rx` passes through a 2-FF synchronizer. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP (plus PARITY when configured).
- **IDLE:** a high-to-low transition on the synchronized rx moves the FSM to START. The bit counter loads `CLKS_PER_BIT/2 - 1`.
- **START:** at counter zero, sample rx.
  - rx = 1: false start, return to IDLE with no output.
  - rx = 0: go to DATA. Counter loads `CLKS_PER_BIT - 1`, bit index = 0.
- **DATA:** at each counter zero, sample rx into the shift register, LSB first, and reload the counter. After bit index 7, go to STOP (or PARITY).
- **STOP:** at counter zero, sample rx.
  - rx = 1: push the byte into the FIFO. If the FIFO is full, drop the byte and pulse `rx_overflow`.
  - rx = 0: pulse `rx_frame_err` and discard the byte.
  - Either way, return to IDLE in the same cycle. Back-to-back frames are therefore supported, since the next start edge is detected at most half a bit later.
- **Counter width:** `$clog2(CLKS_PER_BIT)` bits; it counts down. Bit index is 3 bits.
- **Stream rule:** a FIFO pop happens when `m_axis_rvalid && m_axis_rready`.
  - A push and a pop in the same cycle are both honored, including when the FIFO is full: that push succeeds and no overflow is flagged.
  - `m_axis_rdata` is stable while `rvalid` is high and `rready` is low.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)+1` bits. Full and empty are derived from the MSB compare, and pointers wrap naturally.

## Timing
- **Reset values:** `m_axis_rvalid`=0, `m_axis_rdata`=0, `rx_frame_err`=0, `rx_overflow`=0. FSM = IDLE, FIFO empty, synchronizer = 1.
- **Reset mid-frame:** the partial byte is lost. The next complete frame is received normally.
- **Edge-to-sample latency:** 2 cycles of sync delay from the `rx` pin to the FSM.
- **Sampling points:**
  - Start bit sampled `CLKS_PER_BIT/2` cycles after the detected edge.
  - Each later bit sampled `CLKS_PER_BIT` cycles after the previous sample.
- **Output latency:** `m_axis_rvalid` rises on the cycle after the stop-bit sample cycle when the FIFO was empty.
- **Error pulses:** `rx_frame_err` and `rx_overflow` are asserted on the cycle after the stop-bit sample and last exactly one cycle.
- **Throughput:** one word per cycle out of the FIFO.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - Frame format is 8E1.
  - PARITY state follows DATA and samples one extra bit.
  - Even-parity mismatch raises the output port `rx_parity_err` (one-cycle pulse, reset 0) and discards the byte; the stop bit is still checked.
  - Frame error takes precedence if both errors occur; only `rx_frame_err` pulses.
- **`UART_RX_PARITY_EN` undefined:** frame format is 8N1, the PARITY state and the `rx_parity_err` port do not exist.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum `uart_rx_state_t`.
  - `UART_DATA_BITS = 8`.
  - `UART_WORD_W = 32`.
- **Sub-module `sync_fifo`:**
  - Parameterized width and depth; single clock, synchronous active-high reset.
  - Show-ahead read data, with push/pop/full/empty ports.
  - Instantiated with width 8; zero-extension to 32 bits happens in `uart_rx_axis`.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and `FIFO_DEPTH=8` unless stated.
- **Single byte:** one 8N1 frame of 0xA5, `rready`=1 -> a single beat with `m_axis_rdata`=0x000000A5, `rvalid` rising 1 cycle after the stop sample.
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap -> two beats, 0x00000000 then 0x000000FF, no error pulses.
- **Glitch rejection:** `rx` low for 4 cycles then high -> no beat and no error pulses; the FSM returns to IDLE.
- **Framing error:** frame of 0x3C with the stop bit driven 0 -> one `rx_frame_err` pulse, no beat. A following good 0x55 is received as 0x00000055.
- **Overflow:** `rready`=0, send 9 frames 0x01..0x09 -> `rx_overflow` pulses once, on byte 0x09. Then raise `rready` -> beats 0x01..0x08 in order, then `rvalid`=0.
- **Reset mid-frame:** assert `rst` for 1 cycle during DATA bit 4 -> all outputs 0 next cycle. A following frame of 0x81 is received as 0x00000081.
- **Parity (with `UART_RX_PARITY_EN`):** frame 0x07 with parity bit 0 -> one `rx_parity_err` pulse, no beat. The same frame with parity bit 1 -> beat 0x00000007.
